// File: rtl/tpu_pkg.sv
// tpu_pkg: shared defaults, operand/accumulator types and fill-latency helper
// for the systolic_array matrix-multiply block and its tpumac cells.
//   DEF_BITS_AB  default signed operand width (A and B)
//   DEF_BITS_C   default signed accumulator width (C)
//   DEF_DIM      default square array dimension
//   FILL_CYCLES  enabled cycles until a full product has drained through
package tpu_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;

  typedef logic signed [DEF_BITS_AB-1:0] operand_t;
  typedef logic signed [DEF_BITS_C-1:0]  acc_t;

  // The last term reaches cell(DIM-1,DIM-1) at enabled step 3*DIM-3,
  // so 3*DIM-2 enabled cycles are needed from the first valid edge input.
  function automatic int fill_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

  localparam int FILL_CYCLES = fill_cycles(DEF_DIM);

endpackage

// File: rtl/tpumac.sv
// tpumac: one output-stationary multiply-accumulate cell.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears operands and accumulator
//   en    shift operands through and accumulate Ain*Bin
//   WrEn  load Cin into the accumulator (wins over accumulation)
//   Ain   operand arriving from the left neighbour (or the array edge)
//   Bin   operand arriving from the upper neighbour (or the array edge)
//   Cin   preload value for the accumulator
//   Aout  registered A, forwarded to the right neighbour
//   Bout  registered B, forwarded to the lower neighbour
//   Cout  accumulator contents
module tpumac
  import tpu_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);

  localparam int PW = 2 * BITS_AB;
  localparam int XW = (PW > BITS_C) ? PW : BITS_C;

  // Sign-extend or truncate the full product to the accumulator width,
  // then add with modulo-2^BITS_C wrap (no saturation).
  function automatic logic signed [BITS_C-1:0] wrap_acc(
    input logic signed [BITS_C-1:0] acc,
    input logic signed [PW-1:0]     prod
  );
    logic signed [XW-1:0] prod_x;
    prod_x = XW'(prod);
    return acc + prod_x[BITS_C-1:0];
  endfunction

  logic signed [BITS_AB-1:0] a_q, a_d;
  logic signed [BITS_AB-1:0] b_q, b_d;
  logic signed [BITS_C-1:0]  c_q, c_d;
  logic signed [PW-1:0]      prod;

  // Multiply the operands entering this cycle, not the registered copies.
  assign prod = PW'(Ain) * PW'(Bin);

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (en) begin
      a_d = Ain;
      b_d = Bin;
    end
    if (WrEn) begin
      c_d = Cin;
    end else if (en) begin
      c_d = wrap_acc(c_q, prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  assign Aout = a_q;
  assign Bout = b_q;
  assign Cout = c_q;

endmodule

// File: rtl/systolic_array.sv
// systolic_array: DIM x DIM output-stationary grid of signed MAC cells.
// A streams in from the left (one cell right per enabled cycle), B from the
// top (one cell down per enabled cycle); every cell accumulates its own C.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   en    advance the array one step
//   WrEn  preload C row Crow from Cin
//   Crow  row select for preload and readback
//   A     left-edge operands, A[r] feeds row r
//   B     top-edge operands, B[c] feeds column c
//   Cin   row preload data
//   Cout  C row Crow, combinational read
//   done  3*DIM-2 enabled cycles elapsed since reset or last preload
module systolic_array
  import tpu_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic [$clog2(DIM)-1:0]    Crow,
  input  logic signed [BITS_AB-1:0] A    [DIM],
  input  logic signed [BITS_AB-1:0] B    [DIM],
  input  logic signed [BITS_C-1:0]  Cin  [DIM],
  output logic signed [BITS_C-1:0]  Cout [DIM],
  output logic                      done
);

  localparam int RW     = $clog2(DIM);
  localparam int FILL_N = fill_cycles(DIM);
  localparam int CNT_W  = $clog2(FILL_N + 1);

  logic signed [BITS_AB-1:0] a_w [DIM][DIM];
  logic signed [BITS_AB-1:0] b_w [DIM][DIM];
  logic signed [BITS_C-1:0]  c_w [DIM][DIM];

  for (genvar r = 0; r < DIM; r++) begin : g_row
    logic row_wr;
    assign row_wr = WrEn && (Crow == RW'(r));

    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic signed [BITS_AB-1:0] ain;
      logic signed [BITS_AB-1:0] bin;

      if (c == 0) begin : g_a_edge
        assign ain = A[r];
      end else begin : g_a_int
        assign ain = a_w[r][c-1];
      end

      if (r == 0) begin : g_b_edge
        assign bin = B[c];
      end else begin : g_b_int
        assign bin = b_w[r-1][c];
      end

      tpumac #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C)
      ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .WrEn (row_wr),
        .Ain  (ain),
        .Bin  (bin),
        .Cin  (Cin[c]),
        .Aout (a_w[r][c]),
        .Bout (b_w[r][c]),
        .Cout (c_w[r][c])
      );
    end
  end

  always_comb begin
    for (int c = 0; c < DIM; c++) begin
      Cout[c] = c_w[Crow][c];
    end
  end

  // Saturating count of enabled cycles; any preload starts a new product.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (WrEn) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(FILL_N))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q >= CNT_W'(FILL_N));

endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: drives skewed A/B streams like memA/memB would and
// compares every C element against a plain matrix-multiply reference.
module tb_systolic_array;
  import tpu_pkg::*;

  localparam int DIM  = DEF_DIM;
  localparam int BC   = DEF_BITS_C;
  localparam int RW   = $clog2(DIM);
  localparam int FILL = FILL_CYCLES;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          WrEn;
  logic [RW-1:0] Crow;
  operand_t      A    [DIM];
  operand_t      B    [DIM];
  acc_t          Cin  [DIM];
  acc_t          Cout [DIM];
  logic          done;

  systolic_array #(
    .BITS_AB (DEF_BITS_AB),
    .BITS_C  (DEF_BITS_C),
    .DIM     (DIM)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .WrEn (WrEn),
    .Crow (Crow),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Cout (Cout),
    .done (done)
  );

  always #5 clk = ~clk;

  int Am [DIM][DIM];
  int Bm [DIM][DIM];
  int Cm [DIM][DIM];
  int wr [DIM];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap_c(input int v);
    acc_t t;
    t = v[BC-1:0];
    return int'(t);
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < DIM; i++) begin
      A[i]   = '0;
      B[i]   = '0;
      Cin[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    en   = 1'b0;
    WrEn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        Cm[r][c] = 0;
  endtask

  task automatic write_row(input int r);
    @(negedge clk);
    WrEn = 1'b1;
    Crow = RW'(r);
    for (int c = 0; c < DIM; c++) begin
      Cin[c]   = acc_t'(wr[c]);
      Cm[r][c] = wrap_c(wr[c]);
    end
    @(negedge clk);
    WrEn = 1'b0;
  endtask

  // mode 0: no stalls; 1: en low at cycles 5, 11, 17; 2: random stalls
  task automatic run(input int max_steps, input int mode);
    int  t;
    int  cyc;
    bit  stall;
    int  s;
    t   = 0;
    cyc = 0;
    while (t < max_steps) begin
      @(negedge clk);
      stall = (mode == 1 && (cyc == 5 || cyc == 11 || cyc == 17)) ||
              (mode == 2 && $urandom_range(0, 3) == 0);
      if (stall) begin
        en = 1'b0;
      end else begin
        en = 1'b1;
        for (int i = 0; i < DIM; i++) begin
          A[i] = '0;
          B[i] = '0;
          if (t - i >= 0 && t - i < DIM) begin
            A[i] = operand_t'(Am[i][t-i]);
            B[i] = operand_t'(Bm[t-i][i]);
          end
        end
        t++;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (!stall && t == FILL - 1) check("done_before_fill", int'(done), 0);
      if (!stall && t == FILL)     check("done_at_fill", int'(done), 1);
    end
    @(negedge clk);
    en = 1'b0;
    clear_inputs();
    if (max_steps >= FILL) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          s = Cm[r][c];
          for (int k = 0; k < DIM; k++) s += Am[r][k] * Bm[k][c];
          Cm[r][c] = wrap_c(s);
        end
    end
  endtask

  task automatic check_mat(input string tag);
    for (int r = 0; r < DIM; r++) begin
      @(negedge clk);
      Crow = RW'(r);
      #1;
      for (int c = 0; c < DIM; c++)
        check($sformatf("%s[%0d][%0d]", tag, r, c), int'(Cout[c]), Cm[r][c]);
    end
  endtask

  task automatic set_const(input int av, input int bv);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        Am[r][c] = av;
        Bm[r][c] = bv;
      end
  endtask

  task automatic set_ident_a(input bit b_ident);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        Am[r][c] = (r == c) ? 1 : 0;
        Bm[r][c] = b_ident ? ((r == c) ? 1 : 0) : r * DIM + c;
      end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    WrEn = 1'b0;
    Crow = '0;
    clear_inputs();

    do_reset();
    check_mat("reset");
    check("reset_done", int'(done), 0);

    set_const(1, 1);
    run(FILL, 0);
    check_mat("ones");
    check("ones_done", int'(done), 1);

    do_reset();
    set_ident_a(1'b0);
    run(FILL, 0);
    check_mat("ident");

    do_reset();
    set_ident_a(1'b1);
    run(FILL, 0);
    check_mat("diag");

    do_reset();
    for (int c = 0; c < DIM; c++) wr[c] = 100;
    write_row(3);
    set_const(1, 1);
    run(FILL, 0);
    check_mat("preload");
    check("preload_done", int'(done), 1);
    for (int c = 0; c < DIM; c++) wr[c] = -7;
    write_row(0);
    check("wren_clears_done", int'(done), 0);
    check_mat("row0_write");

    do_reset();
    set_const(127, 127);
    run(FILL, 0);
    check_mat("wrap");

    do_reset();
    set_ident_a(1'b0);
    run(FILL, 1);
    check_mat("stall");

    do_reset();
    set_const(1, 1);
    run(10, 0);
    do_reset();
    check_mat("midrst");
    check("midrst_done", int'(done), 0);
    run(FILL, 0);
    check_mat("fresh");

    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) wr[c] = int'($urandom_range(0, 65535)) - 32768;
        write_row(r);
      end
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          Am[r][c] = int'($urandom_range(0, 255)) - 128;
          Bm[r][c] = int'($urandom_range(0, 255)) - 128;
        end
      run(FILL, (it == 2) ? 2 : 0);
      check_mat($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- DIM x DIM output-stationary grid of signed multiply-accumulate cells, directly downstream of memA and memB.
- memA's skewed row stream enters the left edge; each A value moves one cell right per enabled cycle.
- memB's skewed column stream enters the top edge; each B value moves one cell down per enabled cycle.
- Each cell accumulates its C element in place. The host preloads C rows and reads them back one row at a time through a row-addressed port.

Parameters:
BITS_AB, 8, signed width of A and B operands
BITS_C, 16, signed width of each C accumulator
DIM, 8, array dimension; square grid DIM x DIM

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
en  in  1  advance the array one step: shift operands, accumulate
WrEn  in  1  write Cin into C row Crow
Crow  in  $clog2(DIM)  row select for write and read
A  in  DIM x BITS_AB signed  left-edge operands; A[r] feeds row r, from memA Aout
B  in  DIM x BITS_AB signed  top-edge operands; B[c] feeds column c, from memB Bout
Cin  in  DIM x BITS_C signed  row data for WrEn
Cout  out  DIM x BITS_C signed  C row Crow, combinational read
done  out  1  high once 3*DIM-2 enabled cycles have elapsed since reset/clear

Behaviour:
- Cell(r,c) registers:
  - a_q: from cell(r,c-1), or A[r] when c=0.
  - b_q: from cell(r-1,c), or B[c] when r=0.
  - c_q: accumulator.
- On rising clk, priority order:
  - rst: every a_q, b_q, c_q clears to 0; the en counter clears to 0; done goes to 0.
  - Else, row r with WrEn=1 and Crow=r:
    - c_q(r,c) <= Cin[c] for every c.
    - If en=1, a_q and b_q in that row still shift; the write wins over accumulation.
    - The en counter clears to 0, because a preload starts a new product.
  - Else, en=1: a_q <= left input, b_q <= upper input, c_q <= c_q + a_in*b_in.
    - a_in and b_in are the values entering the cell this cycle, not the registered copies.
  - Else: hold all state.
- Arithmetic:
  - The product is full signed 2*BITS_AB wide, sign-extended or truncated to BITS_C.
  - The sum wraps modulo 2^BITS_C. No saturation, no overflow flag.
- Cout[c] = c_q(Crow,c), combinational with zero latency. A write is visible on Cout the cycle after WrEn.
- Feed contract:
  - memA delays row r by r cycles and memB delays column c by c cycles.
  - Both present 0 outside their valid window.
  - Cell(r,c) receives its k-th term at enabled cycle r+c+k.
  - After 3*DIM-2 enabled cycles from the first valid edge input, C = Cpre + A x B.
- done:
  - A saturating counter increments on each en=1 cycle.
  - done=1 while count >= 3*DIM-2 and stays high until rst or any WrEn.
- Boundary cases:
  - en=0 mid-stream: the pipeline freezes with no loss. Upstream must freeze too; memA and memB share the same en.
  - rst mid-operation: everything is zeroed at the next edge; partial sums are discarded.
  - Crow is always in range; DIM must be a power of two.
- Reset values: Cout = 0 for all columns, done = 0.

Decomposition:
- tpu_pkg holds:
  - BITS_AB, BITS_C and DIM defaults.
  - Typedefs operand_t (signed BITS_AB) and acc_t (signed BITS_C).
  - Localparam FILL_CYCLES = 3*DIM-2.
- Sub-module tpumac (one cell):
  - Ports: clk, rst, en, WrEn, Ain, Bin, Cin, Aout, Bout, Cout.
  - Instantiated DIM x DIM via generate; row-select decode for WrEn sits in systolic_array.
- The done counter stays in the top level.

Test Plan:
- Reset: rst=1 for 1 cycle, sweep Crow 0..7 -> every Cout element 0, done=0.
- Ones: memA and memB loaded with all 1, en for 22 cycles -> every C element 8. done rises exactly on the edge of the 22nd en; after 21 en it is still 0.
- Identity: A=I, B[i][j]=i*8+j, skewed feed, 22 en -> Cout row r = r*8..r*8+7. The same run with A=B=I gives a diagonal of 1.
- Preload + wrap:
  - WrEn row 3 Cin=100 each, then the ones product -> row 3 = 108, other rows 8, done=1.
  - A=B=127 everywhere -> each C = -2040 (129032 mod 2^16).
- Stall: insert 3 en=0 gaps at cycles 5, 11 and 17 of the identity run -> result identical, done after 22 en-high cycles (25 total).
- Mid-op reset: rst after 10 en cycles -> next cycle all Cout 0, done=0. A fresh 22-cycle ones run then gives 8 everywhere.
